// File: rtl/vga_palette_output.sv
// VGA timing generator, frame-buffer address generator and palette lookup.
// Sync, blank and frame markers are delayed to line up with memory read data.
module vga_palette_output #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int BIN_W       = 3,
    parameter int ADDR_W      = 19,
    parameter int MEM_LATENCY = 2,
    parameter int SCALE       = 0,
    parameter bit SYNC_POL    = 1'b0,
    localparam int NUM_COLORS = 2**BIN_W - 1
) (
    input  logic                    video_clk,
    input  logic                    reset,
    input  logic                    ready,
    input  logic [BIN_W-1:0]        bin_data,
    input  logic [12*NUM_COLORS-1:0] palette,
    output logic [ADDR_W-1:0]       memory_addr,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    active,
    output logic                    frame_start,
    output logic [11:0]             video_out
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_MASK  = HW'((1 << SCALE) - 1);

    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_MASK  = VW'((1 << SCALE) - 1);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE >> SCALE);

    // Stage-0 state: beam position, incremental address terms, ready tag.
    logic [HW-1:0]     h;
    logic [VW-1:0]     v;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row_base;
    logic              run;
    logic              rdy;

    logic [HW-1:0]     h_next;
    logic [VW-1:0]     v_next;
    logic [ADDR_W-1:0] col_next;
    logic [ADDR_W-1:0] row_next;
    logic [ADDR_W-1:0] addr_next;

    // Next beam position; the first clock out of reset holds (0,0).
    always_comb begin
        h_next   = h;
        v_next   = v;
        col_next = col;
        row_next = row_base;
        if (run) begin
            if (h == H_LAST) begin
                h_next   = '0;
                col_next = '0;
                if (v == V_LAST) begin
                    v_next   = '0;
                    row_next = '0;
                end else begin
                    v_next = v + 1'b1;
                    if ((v & V_MASK) == V_MASK)
                        row_next = row_base + ROW_STEP;
                end
            end else begin
                h_next = h + 1'b1;
                if ((h & H_MASK) == H_MASK)
                    col_next = col + 1'b1;
            end
        end
        addr_next = '0;
        if (ready && (h_next < H_ACT) && (v_next < V_ACT))
            addr_next = col_next + row_next;
    end

    // Register beam position, address and the ready tag together.
    always_ff @(posedge video_clk) begin
        if (reset) begin
            h           <= '0;
            v           <= '0;
            col         <= '0;
            row_base    <= '0;
            run         <= 1'b0;
            rdy         <= 1'b0;
            memory_addr <= '0;
        end else begin
            h           <= h_next;
            v           <= v_next;
            col         <= col_next;
            row_base    <= row_next;
            run         <= 1'b1;
            rdy         <= ready;
            memory_addr <= addr_next;
        end
    end

    // Timing flags for the current beam position: {hs, vs, act, fs}.
    logic [3:0] flags;

    // Decode sync windows, visibility and frame origin.
    always_comb begin
        flags    = '0;
        flags[3] = (h >= HS_BEG) && (h < HS_END);
        flags[2] = (v >= VS_BEG) && (v < VS_END);
        flags[1] = rdy && (h < H_ACT) && (v < V_ACT);
        flags[0] = run && (h == '0) && (v == '0);
    end

    logic [3:0] dly [MEM_LATENCY];

    // Delay the flags by the memory read latency.
    always_ff @(posedge video_clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_LATENCY; i++)
                dly[i] <= '0;
        end else begin
            dly[0] <= flags;
            for (int i = 1; i < MEM_LATENCY; i++)
                dly[i] <= dly[i-1];
        end
    end

    logic [11:0] pal [2**BIN_W];

    // Unpack the flat palette; index 0 is always black.
    always_comb begin
        pal[0] = 12'h000;
        for (int k = 1; k <= NUM_COLORS; k++)
            pal[k] = palette[12*(k-1) +: 12];
    end

    logic [3:0] tail;
    assign tail = dly[MEM_LATENCY-1];

    // Output register: colour lookup plus aligned sync and markers.
    always_ff @(posedge video_clk) begin
        if (reset) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            active      <= 1'b0;
            frame_start <= 1'b0;
            video_out   <= 12'h000;
        end else begin
            hsync       <= tail[3] ? SYNC_POL : ~SYNC_POL;
            vsync       <= tail[2] ? SYNC_POL : ~SYNC_POL;
            active      <= tail[1];
            frame_start <= tail[0];
            video_out   <= tail[1] ? pal[bin_data] : 12'h000;
        end
    end

endmodule

// File: doc/vga_palette_output.md
Name: vga_palette_output

Overview:
- Parametrised successor to the fixed 640x480 colour-output stage.
- Generates VGA timing and a frame-buffer read address, then maps each returned bin index through a flattened palette to 12-bit RGB.
- Timing, palette size, memory read latency, pixel-replication scale and sync polarity are all parameters. Sync and blank are delay-aligned to the memory return automatically, replacing hand-placed delay kludges.
- Sits between the bin-index frame buffer (BRAM) and the VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
BIN_W, 3, bin index width; NUM_COLORS = 2^BIN_W - 1
ADDR_W, 19, frame-buffer address width
MEM_LATENCY, 2, clocks from memory_addr to valid bin_data (1..4)
SCALE, 0, pixel replication shift: each stored pixel covers 2^SCALE x 2^SCALE screen pixels (0..2)
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
video_clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
ready  in  1  frame buffer readable; when low, address is forced to 0 and output is black
bin_data  in  BIN_W  bin index returned by the frame buffer
palette  in  12*NUM_COLORS  colour for index k (k>=1) at bits [12*(k-1) +: 12]; index 0 is black
memory_addr  out  ADDR_W  frame-buffer read address
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
active  out  1  output pixel lies in the visible area
frame_start  out  1  one-clock pulse aligned with output pixel (0,0)
video_out  out  12  RGB 4:4:4

Behaviour:
- Counters (stage 0):
  - h runs 0..H_TOT-1, where H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP. v runs 0..V_TOT-1 and increments only when h wraps. Both wrap to 0 together at (H_TOT-1, V_TOT-1).
  - Default totals: 800 x 525.
- Address (stage 0, registered alongside h and v):
  - For counter state (h,v) with h<H_ACTIVE, v<V_ACTIVE and ready=1: memory_addr = (h>>SCALE) + (v>>SCALE)*(H_ACTIVE>>SCALE).
  - Otherwise memory_addr = 0.
  - Computed incrementally with a column counter and a row-base register; no multiplier. The row base advances by H_ACTIVE>>SCALE only on lines where v[SCALE-1:0] is all ones (every line when SCALE=0), and clears at v wrap.
- Timing decode, applied to (h,v) and carried through the delay line:
  - hs_on = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs_on = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC
  - act = h<H_ACTIVE && v<V_ACTIVE && ready
  - fs = (h==0 && v==0)
- Alignment:
  - hs_on, vs_on, act and fs are delayed MEM_LATENCY clocks, then registered together with video_out. Total latency is PIPE = MEM_LATENCY+1 clocks from counter state (h,v) to all outputs for that pixel.
  - hsync = hs_on_d ? SYNC_POL : ~SYNC_POL; vsync is derived the same way from vs_on_d.
  - video_out = act_d ? (bin_data==0 ? 12'h000 : palette entry bin_data) : 12'h000.
  - active = act_d; frame_start = fs_d.
- ready handling: ready is sampled at stage 0 and travels with the pixel. A mid-frame change affects only pixels generated after it; syncs are never interrupted.
- Reset:
  - h=v=0, row base and column counter 0, all delay stages cleared.
  - Outputs: memory_addr=0, video_out=0, active=0, frame_start=0, hsync=vsync=~SYNC_POL.
  - First clock after reset deasserts: counters hold (0,0) and the address is computed for it. Outputs for that pixel appear PIPE clocks later. Reset asserted mid-frame restarts from (0,0) on the next edge.
- Palette is sampled combinationally at the output register; a change takes effect on the next clock.

Test Plan:
- Defaults, ready=1, bin_data tied 3'b001, palette[11:0]=12'hF00:
  - frame_start pulses once every 420000 clocks.
  - hsync is low for exactly 96 clocks starting 656 pixel positions after line start.
  - vsync is low for 2 lines (1600 clocks).
  - active is high for 640x480 pixels per frame, and video_out=12'hF00 exactly while active=1.
- Memory model returning bin = addr[2:0] after MEM_LATENCY=2: at the first output pixel where active=1, video_out is black (index 0). The next pixel shows palette entry 1. Repeat with MEM_LATENCY=1 and 4 and confirm no misalignment.
- SCALE=1, defaults otherwise:
  - memory_addr sequence on line 0 is 0,0,1,1,...,319,319.
  - Line 1 repeats line 0's addresses; line 2 starts at 320.
  - The last active pixel address is 76799.
- ready low for lines 100-109 mid-frame: memory_addr=0 and video_out=0 on those lines; hsync and vsync periods are unchanged; normal output resumes at line 110.
- Reset asserted at h=300, v=200: on the next clock all outputs take their reset values. frame_start pulses exactly PIPE clocks after reset deasserts.
- SYNC_POL=1: sync pulses invert (high during sync) and the reset level is 0.
